alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Initiator side of the 5-bit ALU interface: accepts packed instructions over a valid/ready handshake and holds an 8-entry register file.
- Decodes each instruction into ALU operands a, b and function code f, waits out the ALU's one-clock registered latency, then writes y back to the register file and updates a carry flag from cout.
- Sits between the instruction source and the ALU, and is the only block that drives ALU inputs.

Parameters:
- DATA_W, 5, operand/register width; must match the ALU width.
- REG_AW, 3, register address width (2**REG_AW registers, r0 hardwired to zero).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction valid
- in_ready  output  1  sequencer can accept an instruction
- in_instr  input  18  {op[17:15], rd[14:12], rs1[11:9], rs2[8:6], use_imm[5], imm[4:0]}
- alu_a  output  DATA_W  ALU operand a (registered)
- alu_b  output  DATA_W  ALU operand b (registered)
- alu_f  output  3  ALU function code (registered)
- alu_y  input  DATA_W  ALU result (registered inside ALU)
- alu_cout  input  1  ALU carry out (registered inside ALU)
- done  output  1  one-cycle pulse, instruction retired
- result  output  DATA_W  last written-back value
- carry_flag  output  1  sticky carry from last ADD-class op
- dbg_addr  input  REG_AW  debug register-file read address
- dbg_data  output  DATA_W  combinational register-file read

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all registers r0..r7=0, alu_a=alu_b=0, alu_f=0, done=0, result=0, carry_flag=0. in_ready=1 once out of reset. Reset asserted mid-instruction abandons it; no write-back occurs.
- ALU f encoding: f[2] inverts b; f[1:0] 00=AND, 01=OR, 10=ADD, 11=SLT (SLT ignores the inversion and compares unsigned a<b). f=110 gives a+~b = a-b-1, mod 32.
- Decode at accept:
  - op 000-110: alu_f=op, alu_a=R[rs1], alu_b = use_imm ? imm : R[rs2].
  - op 111 (MOV): alu_f=001, alu_a=R[rs1], alu_b = use_imm ? imm : 0.
  - Load-immediate is op=001, rs1=0, use_imm=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at edge E0: latch rd and the ADD-class bit (alu_f[1:0]==10), register alu_a/alu_b/alu_f, go ISSUE.
  - ISSUE: in_ready=0; ALU inputs stable; the ALU samples at edge E1; go WB.
  - WB: in_ready=0. At edge E2: if rd!=0, R[rd]=alu_y; result=alu_y; done=1; if ADD-class, carry_flag=alu_cout, else carry_flag holds; go IDLE.
- Timing:
  - done is high exactly one cycle, the cycle after E2, and is cleared at the next edge.
  - Latency from accept to done: 3 edges. Throughput: one instruction per 3 cycles. Next accept is possible at E3.
  - Write-back at E2 precedes any read at E3, so no bypass is required and no hazards exist.
- alu_a/alu_b/alu_f hold their values after ISSUE until the next accept.
- Writes to r0 are discarded; r0 and dbg_data at address 0 always read 0.
- in_valid while in_ready=0 is ignored. The source must hold in_instr stable while in_valid=1 until accepted.
- Arithmetic is the ALU's: results wrap mod 2**DATA_W. The sequencer never modifies alu_y.

Decomposition:
- Shared package: op codes (OP_AND..OP_MOV), F_AND/F_OR/F_ADD/F_SLT and F_INV constants, instruction field bit positions, state enum {IDLE, ISSUE, WB}.
- One sub-module is natural: alu_regfile (2 sync-free combinational read ports plus 1 debug read port, 1 write port, r0 hardwired zero, async reset clear).

Test Plan:
- Reset then load-imm r1=7, r2=30; ADD (op 010) r3=r1+r2 -> r3=5, carry_flag=1, done high one cycle, 3 edges after accept.
- Load r4=3, r5=9; SLT (op 011) r6=r4<r5 -> r6=1; swap operands -> 0; carry_flag unchanged.
- Load r1=22, r2=6; ANDN (op 100) r3 -> 16; op 110 r4=r1,r2 -> 15 (22-6-1), carry_flag=1.
- Hold in_valid high with back-to-back instructions -> in_ready low in ISSUE/WB, accepts spaced 3 cycles, second instruction reads the first's write-back value.
- Write to r0 (rd=0, load-imm 31) -> dbg_data(0)=0, result=31, done pulses.
- Assert rst_n low during ISSUE -> immediate clear of all outputs and registers, no write-back, in_ready=1 after release.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer.
// Instruction layout: {op, rd, rs1, rs2, use_imm, imm}.
package alu_sequencer_pkg;

    localparam int DATA_W  = 5;
    localparam int REG_AW  = 3;
    localparam int INSTR_W = 18;

    localparam int OP_MSB   = 17;
    localparam int OP_LSB   = 15;
    localparam int RD_MSB   = 14;
    localparam int RD_LSB   = 12;
    localparam int RS1_MSB  = 11;
    localparam int RS1_LSB  = 9;
    localparam int RS2_MSB  = 8;
    localparam int RS2_LSB  = 6;
    localparam int UIMM_BIT = 5;
    localparam int IMM_MSB  = 4;
    localparam int IMM_LSB  = 0;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUBN = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    localparam logic [1:0] F_AND = 2'b00;
    localparam logic [1:0] F_OR  = 2'b01;
    localparam logic [1:0] F_ADD = 2'b10;
    localparam logic [1:0] F_SLT = 2'b11;
    localparam logic [2:0] F_INV = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    function automatic logic is_add(input logic [2:0] f);
        return f[1:0] == F_ADD;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake between the source and the sequencer.
// master = instruction source, slave = sequencer.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready
    );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// Register file: two operand reads, one debug read, one write.
// r0 is never written and always reads zero.
module alu_regfile #(
    parameter int DW = 5,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    output logic [DW-1:0] dbg_o
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
    assign dbg_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Drives a registered ALU: decode, issue, wait one clock, write back.
// One instruction retires every three cycles.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = alu_sequencer_pkg::DATA_W,
    parameter int REG_AW = alu_sequencer_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.slave    in_if,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_flag,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              add_q, add_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        f_q, f_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              cy_q, cy_d;

    logic [2:0]        op;
    logic              use_imm;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              we;

    assign op      = in_if.in_instr[OP_MSB:OP_LSB];
    assign use_imm = in_if.in_instr[UIMM_BIT];
    assign imm_ext = DATA_W'(in_if.in_instr[IMM_MSB:IMM_LSB]);

    alu_regfile #(
        .DW(DATA_W),
        .AW(REG_AW)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1_i     (in_if.in_instr[RS1_MSB:RS1_LSB]),
        .ra2_i     (in_if.in_instr[RS2_MSB:RS2_LSB]),
        .dbg_addr_i(dbg_addr),
        .we_i      (we),
        .wa_i      (rd_q),
        .wd_i      (alu_y),
        .rd1_o     (rs1_data),
        .rd2_o     (rs2_data),
        .dbg_o     (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        add_d   = add_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        done_d  = 1'b0;
        res_d   = res_q;
        cy_d    = cy_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_if.in_valid) begin
                    a_d  = rs1_data;
                    rd_d = in_if.in_instr[RD_MSB:RD_LSB];
                    // MOV is an OR against zero or the immediate
                    if (op == OP_MOV) begin
                        f_d = {1'b0, F_OR};
                        b_d = use_imm ? imm_ext : '0;
                    end else begin
                        f_d = op;
                        b_d = use_imm ? imm_ext : rs2_data;
                    end
                    add_d   = is_add(f_d);
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WB;
            WB: begin
                we      = (rd_q != '0);
                res_d   = alu_y;
                done_d  = 1'b1;
                cy_d    = add_q ? alu_cout : cy_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= '0;
            add_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            add_q   <= add_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            done_q  <= done_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
        end
    end

    assign in_if.in_ready = (state_q == IDLE);
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_f          = f_q;
    assign done           = done_q;
    assign result         = res_q;
    assign carry_flag     = cy_q;

endmodule
